// File: rtl/iserdes_gen.sv
// iserdes_gen: bit-rate serial-to-parallel deserializer with internal word strobe, bitslip and master/slave cascade.
// Define ISERDES_GEN_TRAIN_EN to add the ALIGN_START/ALIGNED/ALIGN_FAIL word-alignment training FSM.
module iserdes_gen #(
   parameter int DATA_WIDTH = 8,
   parameter BITSLIP_ENABLE = "FALSE",
`ifdef ISERDES_GEN_TRAIN_EN
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'h2C),
`endif
   parameter SERDES_MODE = "NONE"
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CE,
   input  logic                  D,
   input  logic                  SHIFTIN,
   input  logic                  BITSLIP,
`ifdef ISERDES_GEN_TRAIN_EN
   input  logic                  ALIGN_START,
   output logic                  ALIGNED,
   output logic                  ALIGN_FAIL,
`endif
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  VALID,
   output logic                  SHIFTOUT
);
   localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   localparam bit SLIP_EN = BITSLIP_ENABLE == "TRUE";
   logic [DATA_WIDTH-1:0] sr, sr_nx;
   logic [CW-1:0] cnt;
   logic din, slip_lock, int_slip, slip, word;
   assign din = (SERDES_MODE == "SLAVE") ? SHIFTIN : D;
   generate
      if (DATA_WIDTH == 1) begin : g_one
         assign sr_nx = din;
      end else begin : g_multi
         assign sr_nx = {din, sr[DATA_WIDTH-1:1]};
      end
   endgenerate
   // A slip holds the counter so the word boundary lands one bit later; the lock allows one slip per word.
   assign slip = DATA_WIDTH > 1 && CE && !slip_lock && ((SLIP_EN && BITSLIP) || int_slip);
   assign word = CE && cnt == LAST && !slip;
   assign SHIFTOUT = sr[0];
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         sr        <= '0;
         cnt       <= '0;
         Q         <= '0;
         VALID     <= 1'b0;
         slip_lock <= 1'b0;
      end else begin
         VALID <= word;
         if (CE) begin
            sr <= sr_nx;
            if (slip) slip_lock <= 1'b1;
            else cnt <= word ? '0 : cnt + 1'b1;
            if (word) begin
               Q         <= sr_nx;
               slip_lock <= 1'b0;
            end
         end
      end
`ifdef ISERDES_GEN_TRAIN_EN
   typedef enum logic [2:0] {IDLE, CHECK, SLIP, DRAIN, LOCKED, FAIL} st_t;
   st_t st, st_nx;
   logic [CW-1:0] tries, tries_nx;
   assign int_slip   = st == SLIP;
   assign ALIGNED    = st == LOCKED;
   assign ALIGN_FAIL = st == FAIL;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         st    <= IDLE;
         tries <= '0;
      end else begin
         st    <= st_nx;
         tries <= tries_nx;
      end
   // DRAIN skips the word already in flight when the slip landed, so CHECK only sees post-slip words.
   always_comb begin
      st_nx    = st;
      tries_nx = tries;
      if (ALIGN_START) begin
         st_nx    = CHECK;
         tries_nx = '0;
      end else
         case (st)
            CHECK: if (VALID) st_nx = (Q == TRAIN_PATTERN) ? LOCKED : (tries == LAST) ? FAIL : SLIP;
            SLIP:
               if (CE && !slip_lock) begin
                  st_nx    = DRAIN;
                  tries_nx = tries + 1'b1;
               end
            DRAIN: if (VALID) st_nx = CHECK;
            default: ;
         endcase
   end
`else
   assign int_slip = 1'b0;
`endif
endmodule

// File: tb/tb_iserdes_gen.sv
// tb_iserdes_gen: directed checks of iserdes_gen word framing, CE gating, bitslip, async reset and cascade.
// With ISERDES_GEN_TRAIN_EN defined the alignment lock and fail paths are exercised too.
module tb_iserdes_gen;
   logic CLK = 1'b0, RST, CE, D, BITSLIP, as;
   logic [7:0] q8;
   logic [3:0] qm, qs;
   logic q1, v8, vm, vs, v1, so8, som, sos, so1;
   logic al8, af8, alm, afm, als, afs, al1, af1;
   logic [7:0] pa = 8'hA5, pb = 8'h3C, pc = 8'h5A, pt = 8'h61;
   int checks = 0, errors = 0;

   always #5 CLK = ~CLK;

   iserdes_gen #(.DATA_WIDTH(8), .BITSLIP_ENABLE("TRUE"), .SERDES_MODE("NONE")) u_a (
      .CLK(CLK), .RST(RST), .CE(CE), .D(D), .SHIFTIN(1'b0), .BITSLIP(BITSLIP),
`ifdef ISERDES_GEN_TRAIN_EN
      .ALIGN_START(as), .ALIGNED(al8), .ALIGN_FAIL(af8),
`endif
      .Q(q8), .VALID(v8), .SHIFTOUT(so8));

   iserdes_gen #(.DATA_WIDTH(4), .BITSLIP_ENABLE("FALSE"), .SERDES_MODE("MASTER")) u_m (
      .CLK(CLK), .RST(RST), .CE(CE), .D(D), .SHIFTIN(1'b0), .BITSLIP(BITSLIP),
`ifdef ISERDES_GEN_TRAIN_EN
      .ALIGN_START(1'b0), .ALIGNED(alm), .ALIGN_FAIL(afm),
`endif
      .Q(qm), .VALID(vm), .SHIFTOUT(som));

   iserdes_gen #(.DATA_WIDTH(4), .BITSLIP_ENABLE("FALSE"), .SERDES_MODE("SLAVE")) u_s (
      .CLK(CLK), .RST(RST), .CE(CE), .D(D), .SHIFTIN(som), .BITSLIP(BITSLIP),
`ifdef ISERDES_GEN_TRAIN_EN
      .ALIGN_START(1'b0), .ALIGNED(als), .ALIGN_FAIL(afs),
`endif
      .Q(qs), .VALID(vs), .SHIFTOUT(sos));

   iserdes_gen #(.DATA_WIDTH(1), .BITSLIP_ENABLE("TRUE"), .SERDES_MODE("NONE")) u_1 (
      .CLK(CLK), .RST(RST), .CE(CE), .D(D), .SHIFTIN(1'b0), .BITSLIP(BITSLIP),
`ifdef ISERDES_GEN_TRAIN_EN
      .ALIGN_START(1'b0), .ALIGNED(al1), .ALIGN_FAIL(af1),
`endif
      .Q(q1), .VALID(v1), .SHIFTOUT(so1));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic b, input logic ce);
      D = b;
      CE = ce;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      CE = 1'b0;
      BITSLIP = 1'b0;
      as = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; CE = 1'b0; D = 1'b0; BITSLIP = 1'b0; as = 1'b0;
      #12;
      chk("rst_q8", 16'(q8), 16'h0);
      chk("rst_v8", 16'(v8), 16'h0);
      chk("rst_so8", 16'(so8), 16'h0);
      chk("rst_qm", 16'(qm), 16'h0);
      chk("rst_qs", 16'(qs), 16'h0);
      chk("rst_v1", 16'(v1), 16'h0);
      RST = 1'b0;
      for (int i = 0; i < 7; i++) step(pa[i], 1'b1);
      chk("t1_early_v", 16'(v8), 16'h0);
      step(pa[7], 1'b1);
      chk("t1_v_a5", 16'(v8), 16'h1);
      chk("t1_q_a5", 16'(q8), 16'hA5);
      for (int i = 0; i < 8; i++) step(pb[i], 1'b1);
      chk("t1_v_3c", 16'(v8), 16'h1);
      chk("t1_q_3c", 16'(q8), 16'h3C);
      for (int i = 0; i < 8; i++) begin
         step(pa[i], 1'b1);
         chk("t2_v_on", 16'(v8), 16'(i == 7));
         chk("t2_v1_on", 16'(v1), 16'h1);
         chk("t2_q1_on", 16'(q1), 16'(pa[i]));
         step(1'b0, 1'b0);
         chk("t2_v_off", 16'(v8), 16'h0);
         chk("t2_v1_off", 16'(v1), 16'h0);
         chk("t2_q_hold", 16'(q8), 16'(i == 7 ? pa : pb));
      end
      do_reset();
      for (int k = 0; k < 27; k++) begin
         BITSLIP = k < 20;
         step(pa[k % 8], 1'b1);
         chk("t3_v", 16'(v8), 16'(k == 8 || k == 17 || k == 26));
         chk("t3_vm_noslip", 16'(vm), 16'(k % 4 == 3));
         chk("t3_v1_noslip", 16'(v1), 16'h1);
         if (k == 8) chk("t3_q_ror1", 16'(q8), 16'hD2);
         if (k == 17) chk("t3_q_ror2", 16'(q8), 16'h69);
         if (k == 26) chk("t3_q_ror3", 16'(q8), 16'hB4);
      end
      BITSLIP = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) step(pa[i], 1'b1);
      for (int i = 0; i < 4; i++) step(pb[i], 1'b1);
      chk("t4_q_before", 16'(q8), 16'hA5);
      chk("t4_vm_before", 16'(vm), 16'h1);
      #2 RST = 1'b1;
      #1;
      chk("t4_q_async", 16'(q8), 16'h0);
      chk("t4_v_async", 16'(v8), 16'h0);
      chk("t4_vm_async", 16'(vm), 16'h0);
      chk("t4_so_async", 16'(so8), 16'h0);
      @(posedge CLK);
      #1;
      chk("t4_q_held", 16'(q8), 16'h0);
      RST = 1'b0;
      for (int i = 0; i < 7; i++) step(pb[i], 1'b1);
      chk("t4_v_early", 16'(v8), 16'h0);
      step(pb[7], 1'b1);
      chk("t4_v_first", 16'(v8), 16'h1);
      chk("t4_q_first", 16'(q8), 16'h3C);
      do_reset();
      for (int i = 0; i < 4; i++) step(pc[i], 1'b1);
      chk("t5_vm4", 16'(vm), 16'h1);
      chk("t5_qm4", 16'(qm), 16'hA);
      chk("t5_vs4", 16'(vs), 16'h1);
      chk("t5_qs4", 16'(qs), 16'h0);
      for (int i = 4; i < 8; i++) step(pc[i], 1'b1);
      chk("t5_vm8", 16'(vm), 16'h1);
      chk("t5_qm8", 16'(qm), 16'h5);
      chk("t5_vs8", 16'(vs), 16'h1);
      chk("t5_qs8", 16'(qs), 16'hA);
      chk("t5_shiftout", 16'(som), 16'h1);
`ifdef ISERDES_GEN_TRAIN_EN
      do_reset();
      chk("t6_rst_aligned", 16'(al8), 16'h0);
      chk("t6_rst_fail", 16'(af8), 16'h0);
      as = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step(pt[k % 8], 1'b1);
         as = 1'b0;
         if (k == 58) chk("t6_not_yet", 16'(al8), 16'h0);
      end
      chk("t6_aligned", 16'(al8), 16'h1);
      chk("t6_no_fail", 16'(af8), 16'h0);
      do_reset();
      as = 1'b1;
      for (int k = 0; k < 128; k++) begin
         step(1'b1, 1'b1);
         as = 1'b0;
         if (k == 126) chk("t7_not_yet", 16'(af8), 16'h0);
      end
      chk("t7_fail", 16'(af8), 16'h1);
      chk("t7_not_aligned", 16'(al8), 16'h0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
